// File: rtl/fetch_window_buffer.sv
// fetch_window_buffer: pulls 64-bit memory beats into a circular byte queue and presents a 15-byte decode window.
// Latency: a beat accepted at edge N is visible in window/window_valid/count right after edge N (count is registered).
// Backpressure: no request while free space < one beat; at most one request outstanding; byte_incr honoured only when window_valid.
// Ports: clk, reset (async, active-low); redirect_valid/redirect_pc restart fetch at a new PC;
//   req_valid/req_addr/req_ready memory request; resp_valid/resp_data response beat (little-endian);
//   window (byte k at [k*8 +: 8], k=0 oldest), window_valid, window_pc; byte_incr bytes consumed; stall_cycles.
// Optional: define FETCH_STALL_STATS_EN to build the saturating stall_cycles counter; otherwise it is tied to 0.
module fetch_window_buffer #(
  parameter int BUF_BYTES  = 32,
  parameter int BEAT_BYTES = 8,
  parameter int WIN_BYTES  = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [63:0]            redirect_pc,
  output logic                   req_valid,
  output logic [63:0]            req_addr,
  input  logic                   req_ready,
  input  logic                   resp_valid,
  input  logic [63:0]            resp_data,
  output logic [WIN_BYTES*8-1:0] window,
  output logic                   window_valid,
  output logic [63:0]            window_pc,
  input  logic [3:0]             byte_incr,
  output logic [31:0]            stall_cycles
);

  localparam int PTR_W = $clog2(BUF_BYTES);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t           state, state_nxt;
  logic [7:0]       mem [BUF_BYTES];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [63:0]      fetch_addr;
  logic [2:0]       skip;
  logic             drop_pending, drop_nxt;

  logic             space_ok, req_fire, fill_en, consume_en;
  logic [CNT_W-1:0] fill_n, consume_n;

  // A new beat is only asked for when it is guaranteed to fit; consumption
  // while waiting can only grow the free space, so a response never overflows.
  assign space_ok     = (CNT_W'(BUF_BYTES) - count) >= CNT_W'(BEAT_BYTES);
  assign req_valid    = (state == REQ) && space_ok;
  assign req_addr     = fetch_addr;
  assign req_fire     = req_valid && req_ready;
  assign window_valid = count >= CNT_W'(WIN_BYTES);

  // Redirect wins over both fill and consume in the same cycle.
  assign fill_en    = (state == WAIT) && resp_valid && !drop_pending && !redirect_valid;
  assign consume_en = window_valid && (byte_incr != 4'd0) && !redirect_valid;
  assign fill_n     = CNT_W'(BEAT_BYTES) - CNT_W'(skip);
  assign consume_n  = CNT_W'(byte_incr);

  // Window is a rotated view of storage starting at rd_ptr.
  always_comb begin
    window = '0;
    for (int k = 0; k < WIN_BYTES; k++) begin
      window[k*8 +: 8] = mem[rd_ptr + PTR_W'(k)];
    end
  end

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop_pending;
    case (state)
      IDLE: begin
        if (redirect_valid) state_nxt = REQ;
      end
      REQ: begin
        // A request accepted in the redirect cycle belongs to the old stream.
        if (req_fire) begin
          state_nxt = WAIT;
          drop_nxt  = redirect_valid;
        end
      end
      WAIT: begin
        if (resp_valid) begin
          state_nxt = REQ;
          drop_nxt  = 1'b0;
        end else if (redirect_valid) begin
          drop_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      drop_pending <= 1'b0;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fetch_addr   <= 64'd0;
      skip         <= 3'd0;
      window_pc    <= 64'd0;
      for (int i = 0; i < BUF_BYTES; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      state        <= state_nxt;
      drop_pending <= drop_nxt;
      if (redirect_valid) begin
        fetch_addr <= {redirect_pc[63:3], 3'b000};
        skip       <= redirect_pc[2:0];
        window_pc  <= redirect_pc;
        count      <= '0;
        rd_ptr     <= wr_ptr;
      end else begin
        count <= count + (fill_en ? fill_n : '0) - (consume_en ? consume_n : '0);
        if (fill_en) begin
          // Leading bytes below the redirect offset are not part of the stream.
          for (int i = 0; i < BEAT_BYTES; i++) begin
            if (i >= int'(skip)) begin
              mem[wr_ptr + PTR_W'(i) - PTR_W'(skip)] <= resp_data[i*8 +: 8];
            end
          end
          wr_ptr     <= wr_ptr + fill_n[PTR_W-1:0];
          fetch_addr <= fetch_addr + 64'(BEAT_BYTES);
          skip       <= 3'd0;
        end
        if (consume_en) begin
          rd_ptr    <= rd_ptr + consume_n[PTR_W-1:0];
          window_pc <= window_pc + 64'(byte_incr);
        end
      end
    end
  end

`ifdef FETCH_STALL_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= 32'd0;
    end else if (redirect_valid) begin
      stall_q <= 32'd0;
    end else if ((state != IDLE) && !window_valid && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_window_buffer.sv
// Bench for fetch_window_buffer: memory responder, scoreboard queues for request addresses and windows, and a monitor.
module tb_fetch_window_buffer;

  logic          clk;
  logic          reset;
  logic          redirect_valid;
  logic [63:0]   redirect_pc;
  logic          req_valid;
  logic [63:0]   req_addr;
  logic          req_ready;
  logic          resp_valid;
  logic [63:0]   resp_data;
  logic [119:0]  window;
  logic          window_valid;
  logic [63:0]   window_pc;
  logic [3:0]    byte_incr;
  logic [31:0]   stall_cycles;

  fetch_window_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .window         (window),
    .window_valid   (window_valid),
    .window_pc      (window_pc),
    .byte_incr      (byte_incr),
    .stall_cycles   (stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_req[$];
  logic [63:0] exp_win[$];
  int          stream_id = 0;
  int          resp_lat = 0;
  int          resp_id = 0;

  // Memory image: every address holds a distinct, easily recomputed byte.
  function automatic logic [7:0] memb(input logic [63:0] a);
    return a[7:0] ^ (a[15:8] * 8'd3) ^ 8'hA5;
  endfunction

  function automatic logic [63:0] beat(input logic [63:0] a);
    logic [63:0] d;
    d = 64'd0;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = memb(a + 64'(i));
    return d;
  endfunction

  function automatic logic [119:0] exp_window(input logic [63:0] pc);
    logic [119:0] w;
    w = '0;
    for (int k = 0; k < 15; k++) w[k*8 +: 8] = memb(pc + 64'(k));
    return w;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- memory responder ----------------
  logic        hs;
  logic [63:0] hs_addr;
  int          hs_id;
  logic        busy;
  int          dly;
  logic [63:0] b_addr;
  int          b_id;

  initial begin
    resp_valid = 1'b0;
    resp_data  = 64'd0;
    busy       = 1'b0;
    dly        = 0;
    b_addr     = 64'd0;
    b_id       = 0;
    forever begin
      @(negedge clk);
      hs      = reset && req_valid && req_ready;
      hs_addr = req_addr;
      hs_id   = redirect_valid ? stream_id - 1 : stream_id;
      @(posedge clk);
      #1;
      resp_valid = 1'b0;
      if (!reset) begin
        busy = 1'b0;
      end else begin
        if (hs) begin
          busy   = 1'b1;
          dly    = resp_lat;
          b_addr = hs_addr;
          b_id   = hs_id;
        end
        if (busy) begin
          if (dly == 0) begin
            resp_valid = 1'b1;
            resp_data  = beat(b_addr);
            resp_id    = b_id;
            busy       = 1'b0;
          end else begin
            dly--;
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          m_count = 0;
  logic        m_first = 1'b0;
  logic [2:0]  m_skip = 3'd0;
  logic        m_active = 1'b0;
  logic [31:0] m_stall = 32'd0;
  logic [63:0] m_e;

  always @(negedge clk) begin
    if (!reset) begin
      m_count  = 0;
      m_first  = 1'b0;
      m_skip   = 3'd0;
      m_active = 1'b0;
      m_stall  = 32'd0;
    end else begin
      chk("window_valid", window_valid, (m_count >= 15));
      chk("stall_cycles", stall_cycles, m_stall);
      if (req_valid) chk("req_space", (m_count <= 24), 1'b1);
      if (req_valid && req_ready) begin
        if (exp_req.size() == 0) begin
          fail_now("unexpected_req");
        end else begin
          m_e = exp_req.pop_front();
          chk("req_addr", req_addr, m_e);
        end
      end
      if (window_valid && byte_incr != 4'd0) begin
        if (exp_win.size() == 0) begin
          fail_now("unexpected_consume");
        end else begin
          m_e = exp_win.pop_front();
          chk("window_pc", window_pc, m_e);
          chk("window_bytes", window, exp_window(m_e));
        end
      end
`ifdef FETCH_STALL_STATS_EN
      if (redirect_valid) m_stall = 32'd0;
      else if (m_active && m_count < 15 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
      if (redirect_valid) begin
        m_count  = 0;
        m_first  = 1'b1;
        m_skip   = redirect_pc[2:0];
        m_active = 1'b1;
      end else begin
        if (resp_valid && resp_id == stream_id) begin
          m_count = m_count + (m_first ? 8 - int'(m_skip) : 8);
          m_first = 1'b0;
          chk("count_le_32", (m_count <= 32), 1'b1);
        end
        if (window_valid && byte_incr != 4'd0) m_count = m_count - int'(byte_incr);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic redirect(input logic [63:0] pc);
    exp_req.delete();
    for (int i = 0; i < 64; i++) exp_req.push_back({pc[63:3], 3'b000} + 64'(8 * i));
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    req_ready      = 1'b0;
    stream_id++;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    req_ready      = 1'b1;
  endtask

  task automatic consume(input logic [63:0] pc0, input int n, input logic [3:0] inc, input int budget);
    int c;
    for (int i = 0; i < n; i++) exp_win.push_back(pc0 + 64'(i * int'(inc)));
    byte_incr = inc;
    c = 0;
    while (exp_win.size() != 0 && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    byte_incr = 4'd0;
    if (exp_win.size() != 0) begin
      fail_now("consume_timeout");
      exp_win.delete();
    end
  endtask

  task automatic wait_hs(input int budget);
    int c;
    c = 0;
    while (!(req_valid && req_ready) && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (c >= budget) fail_now("handshake_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_req_valid"}, req_valid, 1'b0);
    chk({tag, "_req_addr"}, req_addr, 64'd0);
    chk({tag, "_window_valid"}, window_valid, 1'b0);
    chk({tag, "_window"}, window, 120'd0);
    chk({tag, "_window_pc"}, window_pc, 64'd0);
    chk({tag, "_stall_cycles"}, stall_cycles, 32'd0);
  endtask

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    req_ready      = 1'b1;
    byte_incr      = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b1;
    // No fetch may start before the first redirect.
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("idle_no_req", req_valid, 1'b0);
    end

    // Aligned start; hold consumption so the queue fills to capacity, then steady 7-byte consumption.
    redirect(64'h1000);
    repeat (25) @(posedge clk);
    #1;
    consume(64'h1000, 12, 4'd7, 300);

    // Unaligned start: first beat contributes only 3 bytes.
    redirect(64'h1005);
    consume(64'h1005, 4, 4'd5, 200);

    // Redirect while a response is outstanding: stale beat must be discarded.
    resp_lat = 3;
    redirect(64'h1100);
    wait_hs(50);
    redirect(64'h2000);
    resp_lat = 0;
    consume(64'h2000, 5, 4'd9, 300);

    // Pointer wrap with 13-byte consumption over 10 windows.
    redirect(64'h3003);
    consume(64'h3003, 10, 4'd13, 600);

    // Asynchronous reset while waiting for a response.
    resp_lat = 5;
    redirect(64'h4000);
    wait_hs(50);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    exp_req.delete();
    exp_win.delete();
    resp_lat = 0;
    reset    = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("post_reset_idle", req_valid, 1'b0);
    end

    // Recovery after reset.
    redirect(64'h5000);
    consume(64'h5000, 2, 4'd15, 200);

    repeat (5) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
